cache_level_2: RTL and testbench

Level-2 responder on the L1 miss/write-through interface. It accepts one read-miss or write-through request at a time from the L1 cache and holds `stall_level_2` high for a fixed latency. It then returns the addressed 128-bit block, or commits the 32-bit write word, from an internal block store. It sits between the L1 cache and the rest of the CPU memory system and is the only backing store behind L1.

---
 rtl/cache_level_2_pkg.sv | 22 ++
 rtl/cache_level_2_if.sv | 27 ++
 rtl/l2_block_ram.sv | 40 ++++
 rtl/cache_level_2.sv | 126 ++++++++++++
 tb/tb_cache_level_2.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/cache_level_2_pkg.sv
// Shared types and constants for the level-2 block responder.
package cache_level_2_pkg;

  localparam int WORD_W          = 32;
  localparam int BLOCK_W         = 128;
  localparam int WORDS_PER_BLOCK = 4;
  localparam int L2_LATENCY      = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } l2_state_t;

  // One-hot word enable for the word-in-block select.
  function automatic logic [WORDS_PER_BLOCK-1:0] word_mask(input logic [1:0] sel);
    logic [WORDS_PER_BLOCK-1:0] m;
    m = WORDS_PER_BLOCK'(1) << sel;
    return m;
  endfunction

endpackage

// File: rtl/cache_level_2_if.sv
// L1 miss/write-through bus between the L1 cache (master) and L2 (slave).
// Handshake: L1 raises mem_read_index or mem_write_index with addr/data and
// must hold everything while stall_level_2 is high; the first cycle with
// stall low after a request is the completion cycle, where the block output
// is valid (reads) or the word has been committed (writes). L1 should drop the
// request in that cycle, otherwise the next cycle starts a new request.
interface cache_level_2_if;
  import cache_level_2_pkg::*;

  logic               mem_read_index;
  logic               mem_write_index;
  logic [WORD_W-1:0]  addr_to_mem;
  logic [WORD_W-1:0]  data_to_mem;
  logic               stall_level_2;
  logic [BLOCK_W-1:0] block_of_data_from_cache_level_2;

  modport master (
    output mem_read_index, mem_write_index, addr_to_mem, data_to_mem,
    input  stall_level_2, block_of_data_from_cache_level_2
  );

  modport slave (
    input  mem_read_index, mem_write_index, addr_to_mem, data_to_mem,
    output stall_level_2, block_of_data_from_cache_level_2
  );

endinterface

// File: rtl/l2_block_ram.sv
// Single-port DEPTH x 128 block store with per-word write enables and a
// registered read port. The read register is the block output register seen
// by L1: it loads only on rd_en, holds otherwise and clears on reset. The
// array itself is never reset.
module l2_block_ram
  import cache_level_2_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [AW-1:0]              idx,
  input  logic                       rd_en,
  input  logic [WORDS_PER_BLOCK-1:0] wr_be,
  input  logic [WORD_W-1:0]          wr_word,
  output logic [BLOCK_W-1:0]         rd_data
);

  logic [BLOCK_W-1:0] mem [DEPTH];

  // Word-granular write into the addressed block.
  always_ff @(posedge clk) begin
    for (int w = 0; w < WORDS_PER_BLOCK; w++) begin
      if (wr_be[w]) begin
        mem[idx][w*WORD_W +: WORD_W] <= wr_word;
      end
    end
  end

  // Registered read; value holds between reads.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[idx];
    end
  end

endmodule

// File: rtl/cache_level_2.sv
// Level-2 responder: serialises one L1 read-miss or write-through at a time,
// stalls L1 for LATENCY cycles, then returns a block or commits a word.
module cache_level_2
  import cache_level_2_pkg::*;
#(
  parameter int DEPTH   = 64,
  parameter int LATENCY = L2_LATENCY
) (
  input  logic           clk,
  input  logic           rst,
  cache_level_2_if.slave bus,
  output l2_state_t      state_dbg
);

  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

  l2_state_t                  state_q, state_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic                       op_wr_q;
  logic [AW+1:0]              addr_q;
  logic [WORD_W-1:0]          data_q;

  logic                       req;
  logic                       accept;
  logic                       enter_done;
  logic                       cur_wr;
  logic [AW+1:0]              cur_addr;
  logic [WORD_W-1:0]          cur_data;
  logic                       ram_rd_en;
  logic [WORDS_PER_BLOCK-1:0] ram_wr_be;
  logic                       unused_addr_hi;

  assign req            = bus.mem_read_index | bus.mem_write_index;
  // Address bits above the block index alias onto the same blocks.
  assign unused_addr_hi = ^bus.addr_to_mem[WORD_W-1:AW+2];

  // State and latency counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic: accept in IDLE, count down in BUSY, one DONE cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          accept  = 1'b1;
          cnt_d   = CNT_LOAD;
          state_d = (LATENCY > 1) ? BUSY : DONE;
        end
      end
      BUSY: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Capture op, address and write data when a request is accepted.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_wr_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else if (accept) begin
      op_wr_q <= cur_wr;
      addr_q  <= cur_addr;
      data_q  <= cur_data;
    end
  end

  // Operand select: live bus values in IDLE (needed when LATENCY is 1 and the
  // accept edge is also the completion edge), captured values afterwards.
  always_comb begin
    cur_wr   = op_wr_q;
    cur_addr = addr_q;
    cur_data = data_q;
    if (state_q == IDLE) begin
      cur_wr   = ~bus.mem_read_index;
      cur_addr = bus.addr_to_mem[AW+1:0];
      cur_data = bus.data_to_mem;
    end
  end

  // Reads load the output register and writes commit on the edge into DONE,
  // so a read accepted right after DONE already sees the written word.
  assign enter_done = (state_d == DONE) && (state_q != DONE);
  assign ram_rd_en  = enter_done && !cur_wr;
  assign ram_wr_be  = (enter_done && cur_wr) ? word_mask(cur_addr[1:0]) : '0;

  l2_block_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk     (clk),
    .rst     (rst),
    .idx     (cur_addr[AW+1:2]),
    .rd_en   (ram_rd_en),
    .wr_be   (ram_wr_be),
    .wr_word (cur_data),
    .rd_data (bus.block_of_data_from_cache_level_2)
  );

  assign bus.stall_level_2 = ((state_q == IDLE) && req) || (state_q == BUSY);
  assign state_dbg         = state_q;

endmodule

// File: tb/tb_cache_level_2.sv
// Directed bench for cache_level_2 with a block-store model and an expected
// block queue; one instance at LATENCY=4 and one at LATENCY=1.
module tb_cache_level_2;
  import cache_level_2_pkg::*;

  localparam int DEPTH = 64;
  localparam int AW    = 6;
  localparam int LAT   = 4;

  // Clock and reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cache_level_2_if bus0 ();
  cache_level_2_if bus1 ();
  l2_state_t st0, st1;

  cache_level_2 #(.DEPTH(DEPTH), .LATENCY(LAT)) dut0 (
    .clk (clk), .rst (rst), .bus (bus0), .state_dbg (st0)
  );
  cache_level_2 #(.DEPTH(DEPTH), .LATENCY(1)) dut1 (
    .clk (clk), .rst (rst), .bus (bus1), .state_dbg (st1)
  );

  // Scoreboard state
  int           checks = 0;
  int           errors = 0;
  logic [127:0] exp_q [$];
  logic [127:0] msk_q [$];
  logic [127:0] model [DEPTH];
  logic [3:0]   known [DEPTH];
  logic [127:0] hold_v;
  logic [127:0] hold_m;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] expand(input logic [3:0] k);
    logic [127:0] m;
    for (int w = 0; w < 4; w++) m[w*32 +: 32] = {32{k[w]}};
    return m;
  endfunction

  // Model one request and queue the block output expected at completion.
  function automatic void sb_push(input logic rd, input logic [31:0] a, input logic [31:0] d);
    int b;
    int w;
    b = int'(a[AW+1:2]);
    w = int'(a[1:0]);
    if (rd) begin
      hold_v = model[b];
      hold_m = expand(known[b]);
    end else begin
      model[b][w*32 +: 32] = d;
      known[b][w]          = 1'b1;
    end
    exp_q.push_back(hold_v);
    msk_q.push_back(hold_m);
  endfunction

  // Driver for the LATENCY=4 instance. mode 1: change addr/data mid-BUSY,
  // mode 2: drop the request mid-BUSY, mode 3: keep the write held after DONE.
  task automatic access(input logic rd, input logic wr, input logic [31:0] a,
                        input logic [31:0] d, input int mode, input string tag);
    int n;
    logic [127:0] e;
    logic [127:0] m;
    n = 0;
    @(posedge clk); #1;
    bus0.mem_read_index  = rd;
    bus0.mem_write_index = wr;
    bus0.addr_to_mem     = a;
    bus0.data_to_mem     = d;
    sb_push(rd, a, d);
    while (n < 20) begin
      @(negedge clk);
      if (!bus0.stall_level_2) break;
      n++;
      if (n == 2 && mode == 1) begin
        bus0.addr_to_mem = a ^ 32'h50;
        bus0.data_to_mem = ~d;
      end
      if (n == 2 && mode == 2) begin
        bus0.mem_read_index  = 1'b0;
        bus0.mem_write_index = 1'b0;
      end
    end
    check({tag, "_stall"}, 128'(n), 128'(LAT));
    check({tag, "_state"}, 128'(st0), 128'(DONE));
    e = exp_q.pop_front();
    m = msk_q.pop_front();
    check({tag, "_block"}, bus0.block_of_data_from_cache_level_2 & m, e & m);
    bus0.mem_read_index = 1'b0;
    if (mode != 3) bus0.mem_write_index = 1'b0;
  endtask

  // Driver for the LATENCY=1 instance.
  task automatic access1(input logic rd, input logic [31:0] a, input logic [31:0] d,
                         input logic [127:0] exp_blk, input string tag);
    int n;
    n = 0;
    @(posedge clk); #1;
    bus1.mem_read_index  = rd;
    bus1.mem_write_index = ~rd;
    bus1.addr_to_mem     = a;
    bus1.data_to_mem     = d;
    exp_q.push_back(exp_blk);
    while (n < 20) begin
      @(negedge clk);
      if (!bus1.stall_level_2) break;
      n++;
    end
    check({tag, "_stall"}, 128'(n), 128'(1));
    check({tag, "_block"}, bus1.block_of_data_from_cache_level_2, exp_q.pop_front());
    bus1.mem_read_index  = 1'b0;
    bus1.mem_write_index = 1'b0;
  endtask

  initial begin
    logic [31:0] ra;
    for (int i = 0; i < DEPTH; i++) begin
      model[i] = '0;
      known[i] = '0;
    end
    hold_v = '0;
    hold_m = '1;
    rst = 1'b0;
    bus0.mem_read_index = 1'b0; bus0.mem_write_index = 1'b0;
    bus0.addr_to_mem = '0;      bus0.data_to_mem = '0;
    bus1.mem_read_index = 1'b0; bus1.mem_write_index = 1'b0;
    bus1.addr_to_mem = '0;      bus1.data_to_mem = '0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_stall", 128'(bus0.stall_level_2), 128'(0));
    check("rst_block", bus0.block_of_data_from_cache_level_2, 128'(0));
    check("rst_state", 128'(st0), 128'(IDLE));
    check("rst_block_l1", bus1.block_of_data_from_cache_level_2, 128'(0));
    @(posedge clk); #1 rst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("idle_stall", 128'(bus0.stall_level_2), 128'(0));
      check("idle_block", bus0.block_of_data_from_cache_level_2, 128'(0));
    end

    // Single write then read of the same block
    access(1'b0, 1'b1, 32'h6, 32'hDEADBEEF, 0, "wr_deadbeef");
    access(1'b1, 1'b0, 32'h4, 32'h0, 0, "rd_deadbeef");
    check("deadbeef_word", 128'(bus0.block_of_data_from_cache_level_2[95:64]), 128'(32'hDEADBEEF));

    // Fill block 3, read it back and via an aliased address
    for (int i = 0; i < 4; i++)
      access(1'b0, 1'b1, 32'hC + 32'(i), 32'h11111111 * 32'(i + 1), 0, "fill_b3");
    access(1'b1, 1'b0, 32'hC, 32'h0, 0, "rd_b3");
    check("b3_const", bus0.block_of_data_from_cache_level_2,
          128'h44444444_33333333_22222222_11111111);
    access(1'b1, 1'b0, 32'h10C, 32'h0, 0, "rd_b3_alias");

    // Read and write together: read first, held write served next
    access(1'b1, 1'b1, 32'hD, 32'hAAAA5555, 3, "rdwr_both");
    access(1'b0, 1'b1, 32'hD, 32'hAAAA5555, 0, "rdwr_wr");
    access(1'b1, 1'b0, 32'hC, 32'h0, 0, "rdwr_rd");

    // Inputs changed or dropped mid-BUSY
    access(1'b0, 1'b1, 32'h70, 32'h0BADF00D, 0, "pre_70");
    access(1'b0, 1'b1, 32'h20, 32'h12345678, 1, "chg_wr");
    access(1'b1, 1'b0, 32'h20, 32'h0, 0, "chg_rd20");
    access(1'b1, 1'b0, 32'h70, 32'h0, 0, "chg_rd70");
    access(1'b0, 1'b1, 32'h21, 32'hCAFEF00D, 2, "drop_wr");
    access(1'b1, 1'b0, 32'h20, 32'h0, 0, "drop_rd");

    // Random write/read pairs in the upper blocks
    for (int i = 0; i < 4; i++) begin
      ra = 32'($urandom_range(160, 255));
      access(1'b0, 1'b1, ra, $urandom, 0, "rnd_wr");
      access(1'b1, 1'b0, ra, 32'h0, 0, "rnd_rd");
    end

    // Reset in the second BUSY cycle of a write aborts it
    @(posedge clk); #1;
    bus0.mem_write_index = 1'b1;
    bus0.addr_to_mem     = 32'hE;
    bus0.data_to_mem     = 32'h99999999;
    @(negedge clk);
    check("abort_stall0", 128'(bus0.stall_level_2), 128'(1));
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b0;
    bus0.mem_write_index = 1'b0;
    #1;
    check("abort_stall", 128'(bus0.stall_level_2), 128'(0));
    check("abort_block", bus0.block_of_data_from_cache_level_2, 128'(0));
    check("abort_state", 128'(st0), 128'(IDLE));
    hold_v = '0;
    hold_m = '1;
    @(posedge clk); #1 rst = 1'b1;
    access(1'b1, 1'b0, 32'hC, 32'h0, 0, "abort_rd");
    check("abort_word", 128'(bus0.block_of_data_from_cache_level_2[95:64]), 128'(32'h33333333));

    // LATENCY=1 instance: one stall cycle per request
    for (int i = 0; i < 4; i++)
      access1(1'b0, 32'h14 + 32'(i), 32'hA0000000 + 32'(i), 128'(0), "l1_wr");
    access1(1'b1, 32'h14, 32'h0, 128'hA0000003_A0000002_A0000001_A0000000, "l1_rd");

    check("queue_empty", 128'(exp_q.size()), 128'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
